rtc_port_bridge: RTL and testbench
==================================

// Module: rtc_port_bridge
// PURPOSE
//  PicoBlaze I/O-port bridge to a multiplexed-bus RTC (AD/CS/RD/WR, 8-bit shared addr/data bus).
//  Runs burst transfers of 1..BURST_DEPTH beats with auto-incrementing address and programmable bus timing.
//  Write data and read data pass through internal FIFOs; the CPU polls a status port.
//  Sits between the PicoBlaze port decode and the top-level RTC pins.
// PARAMETERS
//  PORT_ADDR    8'd12  port_id: start-address register (W)
//  PORT_CTRL    8'd13  port_id: control/go register (W)
//  PORT_WDATA   8'd15  port_id: write-FIFO push (W)
//  PORT_STATUS  8'd1   port_id: status (R; read clears done/err)
//  PORT_RDATA   8'd2   port_id: read-FIFO head (R; read pops)
//  BURST_DEPTH  4      FIFO depth and max beats per burst; power of 2, 2..16
//  T_PULSE      4      clk cycles CS+AD/RD/WR held low, min 1
//  T_HOLD       2      clk cycles bus held after strobe release, min 1
//  T_GAP        2      clk cycles idle between address and data phase, min 1
// PORTS
//  clk           in   1  system clock
//  rst           in   1  synchronous reset, active-low
//  read_strobe   in   1  PicoBlaze read strobe
//  write_strobe  in   1  PicoBlaze write strobe
//  port_id       in   8  PicoBlaze port address
//  data_in       in   8  PicoBlaze output data
//  data_out      out  8  data to PicoBlaze (combinational mux on port_id)
//  IRQ           in   1  RTC interrupt, active-low, asynchronous (2-flop synchronised)
//  AD,CS,RD,WR   out  1  RTC strobes, active-low, registered
//  bus           io   8  RTC addr/data bus; hi-Z unless address or write-data phase
// BEHAVIOUR
//  Reset (rst=0 at edge): AD=CS=RD=WR=1, bus hi-Z, FSM IDLE, FIFOs empty, addr=0, status=0.
//  CTRL write: [0]=go, [1]=dir (1 read, 0 write), [7:4]=len-1; len>BURST_DEPTH -> clamp to BURST_DEPTH.
//  go accepted only in IDLE: latch addr/dir/len, busy=1; read burst also flushes read FIFO. go while busy -> ignored, err=1.
//  FSM IDLE->ADDR->AHOLD->GAP->DATA->DHOLD->(next beat: ADDR | last: DONE)->IDLE.
//   ADDR  T_PULSE cyc: CS=0, AD=0, WR=0, bus=addr.   AHOLD T_HOLD cyc: strobes high, bus=addr.
//   GAP   T_GAP cyc: strobes high, bus hi-Z.
//   DATA  T_PULSE cyc: CS=0 and WR=0 (write, bus=wfifo head) or RD=0 (read, bus hi-Z).
//   DHOLD T_HOLD cyc: strobes high; write keeps bus driven; read samples bus on last DATA cycle, pushes rfifo.
//   DONE  1 cyc: busy=0, done=1. Per beat = 2*T_PULSE+2*T_HOLD+T_GAP cycles; go->first CS low = 1 cycle.
//  Address increments after each beat, 8'hFF wraps to 8'h00; ADDR register holds start value.
//  Write beat with wfifo empty -> abort to DONE, err=1, strobes high same cycle.
//  WDATA write when wfifo full -> dropped, err=1. RDATA read when empty -> returns 8'h00, err=1.
//  Pops/clears on read_strobe falling edge (registered strobe history), port_id matching that cycle.
//  STATUS: [0] done [1] busy [2] IRQ level (synced, 1=asserted) [3] rfifo empty [4] wfifo full [5] err [6] irq_flag [7] 0.
//  done set and status-read clear same cycle -> set wins. Unknown port_id reads -> 8'h00.
//  Mid-burst reset -> strobes high next edge, bus released, FIFOs flushed.
// CONFIGURATION
//  IRQ_LATCH_EN defined: status[6] sticky on IRQ falling edge (synced), cleared by STATUS read (set wins).
//  Not defined: status[6] constant 0, edge detector omitted.
// STRUCTURE
//  Package rtc_port_pkg: default port IDs, CTRL/STATUS bit indices, FSM state encoding.
//  Sub-module rtc_bus_seq: FSM + phase counter + pin drivers; top holds port regs, FIFOs, data_out mux.
// TESTING
//  Write ADDR=8'h21, WDATA=8'h5A, CTRL=8'h01 -> AD/WR low with bus=21 for 4 cyc, then WR low bus=5A 4 cyc, done=1.
//  CTRL=8'h33 (read, len 4) addr 8'hFE, model returns 11,22,33,44 -> addresses FE,FF,00,01; RDATA pops 11..44.
//  go while busy -> burst unaffected, status err=1; STATUS read clears done/err.
//  Five WDATA writes with depth 4 -> fifth dropped, wfifo full=1, err=1.
//  rst=0 mid-DATA phase -> next edge all strobes 1, bus hi-Z, status 8'h08 (rfifo empty).
//  IRQ_LATCH_EN: IRQ 1->0 pulse -> status[6]=1 until STATUS read; without macro status[6]=0.

Source files
------------

// File: rtl/rtc_port_pkg.sv
// Shared definitions for the PicoBlaze-to-RTC port bridge: default port IDs,
// CTRL/STATUS bit positions and the bus sequencer state encoding.
package rtc_port_pkg;

    localparam logic [7:0] PID_ADDR   = 8'd12;
    localparam logic [7:0] PID_CTRL   = 8'd13;
    localparam logic [7:0] PID_WDATA  = 8'd15;
    localparam logic [7:0] PID_STATUS = 8'd1;
    localparam logic [7:0] PID_RDATA  = 8'd2;

    localparam int CTRL_GO      = 0;
    localparam int CTRL_DIR     = 1;
    localparam int CTRL_LEN_LSB = 4;
    localparam int CTRL_LEN_MSB = 7;

    localparam int ST_DONE     = 0;
    localparam int ST_BUSY     = 1;
    localparam int ST_IRQ_LVL  = 2;
    localparam int ST_REMPTY   = 3;
    localparam int ST_WFULL    = 4;
    localparam int ST_ERR      = 5;
    localparam int ST_IRQ_FLAG = 6;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_AHOLD = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_DHOLD = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    // Requested beats-1 limited to what the FIFOs can hold.
    function automatic logic [3:0] clamp_last(input logic [3:0] len_m1, input int depth);
        if (int'(len_m1) > depth - 1)
            return 4'(depth - 1);
        return len_m1;
    endfunction

endpackage

// File: rtl/rtc_bus_seq.sv
// RTC multiplexed-bus sequencer: burst FSM, phase down-counter and registered pin drivers.
//  state | meaning
//  IDLE  | waiting for start
//  ADDR  | CS/AD/WR low, address on bus
//  AHOLD | strobes high, address held
//  GAP   | bus released between address and data
//  DATA  | CS plus WR (write, data driven) or RD (read, bus released)
//  DHOLD | strobes high, write data held
//  DONE  | one-cycle burst completion
module rtc_bus_seq
    import rtc_port_pkg::*;
#(
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       start_dir,
    input  logic [7:0] start_addr,
    input  logic [3:0] start_last,
    input  logic       wfifo_empty,
    input  logic [7:0] wfifo_head,
    output logic       wfifo_pop,
    output logic       rfifo_push,
    output logic [7:0] rfifo_data,
    output logic       done_evt,
    output logic       abort_evt,
    output logic       idle,
    output logic       busy,
    output logic       AD,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    inout  wire  [7:0] bus
);

    localparam int CW = 8;
    localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_GAP   = CW'(T_GAP - 1);

    logic [2:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [7:0]    addr, addr_nx;
    logic [3:0]    beats, beats_nx;
    logic          dir, dir_nx;
    logic          bus_oe;
    logic [7:0]    bus_q;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        addr_nx    = addr;
        beats_nx   = beats;
        dir_nx     = dir;
        wfifo_pop  = 1'b0;
        rfifo_push = 1'b0;
        done_evt   = 1'b0;
        abort_evt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    dir_nx   = start_dir;
                    addr_nx  = start_addr;
                    beats_nx = start_last;
                    if (!start_dir && wfifo_empty) begin
                        state_nx  = S_DONE;
                        done_evt  = 1'b1;
                        abort_evt = 1'b1;
                    end else begin
                        state_nx = S_ADDR;
                        cnt_nx   = LD_PULSE;
                    end
                end
            end
            S_ADDR: begin
                if (cnt == '0) begin
                    state_nx = S_AHOLD;
                    cnt_nx   = LD_HOLD;
                end else cnt_nx = cnt - 1'b1;
            end
            S_AHOLD: begin
                if (cnt == '0) begin
                    state_nx = S_GAP;
                    cnt_nx   = LD_GAP;
                end else cnt_nx = cnt - 1'b1;
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_nx  = S_DATA;
                    cnt_nx    = LD_PULSE;
                    wfifo_pop = !dir;
                end else cnt_nx = cnt - 1'b1;
            end
            S_DATA: begin
                if (cnt == '0) begin
                    state_nx   = S_DHOLD;
                    cnt_nx     = LD_HOLD;
                    rfifo_push = dir;
                end else cnt_nx = cnt - 1'b1;
            end
            S_DHOLD: begin
                if (cnt == '0) begin
                    addr_nx = addr + 8'd1;
                    if (beats == '0) begin
                        state_nx = S_DONE;
                        done_evt = 1'b1;
                    end else begin
                        beats_nx = beats - 4'd1;
                        // Write data must be present before a beat starts.
                        if (!dir && wfifo_empty) begin
                            state_nx  = S_DONE;
                            done_evt  = 1'b1;
                            abort_evt = 1'b1;
                        end else begin
                            state_nx = S_ADDR;
                            cnt_nx   = LD_PULSE;
                        end
                    end
                end else cnt_nx = cnt - 1'b1;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Pins are registered from the next state so they move on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            addr   <= '0;
            beats  <= '0;
            dir    <= 1'b0;
            AD     <= 1'b1;
            CS     <= 1'b1;
            RD     <= 1'b1;
            WR     <= 1'b1;
            bus_oe <= 1'b0;
            bus_q  <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            addr   <= addr_nx;
            beats  <= beats_nx;
            dir    <= dir_nx;
            AD     <= !(state_nx == S_ADDR);
            CS     <= !(state_nx == S_ADDR || state_nx == S_DATA);
            WR     <= !(state_nx == S_ADDR || (state_nx == S_DATA && !dir_nx));
            RD     <= !(state_nx == S_DATA && dir_nx);
            bus_oe <= (state_nx == S_ADDR) || (state_nx == S_AHOLD) ||
                      (!dir_nx && (state_nx == S_DATA || state_nx == S_DHOLD));
            if (state_nx == S_ADDR)
                bus_q <= addr_nx;
            else if (wfifo_pop)
                bus_q <= wfifo_head;
        end
    end

    assign bus        = bus_oe ? bus_q : 8'hzz;
    assign rfifo_data = bus;
    assign idle       = (state == S_IDLE);
    assign busy       = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: rtl/rtc_port_bridge.sv
// PicoBlaze port bridge to a multiplexed-bus RTC: port registers, data FIFOs, status and read mux.
// Optional IRQ_LATCH_EN adds a sticky IRQ falling-edge flag in status bit 6.
module rtc_port_bridge
    import rtc_port_pkg::*;
#(
    parameter logic [7:0] PORT_ADDR   = PID_ADDR,
    parameter logic [7:0] PORT_CTRL   = PID_CTRL,
    parameter logic [7:0] PORT_WDATA  = PID_WDATA,
    parameter logic [7:0] PORT_STATUS = PID_STATUS,
    parameter logic [7:0] PORT_RDATA  = PID_RDATA,
    parameter int         BURST_DEPTH = 4,
    parameter int         T_PULSE     = 4,
    parameter int         T_HOLD      = 2,
    parameter int         T_GAP       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       read_strobe,
    input  logic       write_strobe,
    input  logic [7:0] port_id,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       IRQ,
    output logic       AD,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    inout  wire  [7:0] bus
);

    localparam int AW = $clog2(BURST_DEPTH);

    logic [7:0] addr_reg;
    logic       rs_q, done_flag, err_flag, irq_s1, irq_s2, irq_flag;
    logic       wr_addr, wr_ctrl, wr_wdata, rd_fall, rd_status, rd_rdata;
    logic       go, start, err_set;
    logic       seq_pop, seq_push, seq_done, seq_abort, seq_idle, seq_busy;
    logic [7:0] seq_rdata, status;

    logic [7:0]    wmem [BURST_DEPTH];
    logic [7:0]    rmem [BURST_DEPTH];
    logic [AW-1:0] wwp, wrp, rwp, rrp;
    logic [AW:0]   wcnt, rcnt;
    logic          wfull, wempty, rempty, wpush, rpop, rflush;

    assign wr_addr   = write_strobe && (port_id == PORT_ADDR);
    assign wr_ctrl   = write_strobe && (port_id == PORT_CTRL);
    assign wr_wdata  = write_strobe && (port_id == PORT_WDATA);
    // Read side effects happen once, on the strobe's falling edge.
    assign rd_fall   = rs_q && !read_strobe;
    assign rd_status = rd_fall && (port_id == PORT_STATUS);
    assign rd_rdata  = rd_fall && (port_id == PORT_RDATA);

    assign go     = wr_ctrl && data_in[CTRL_GO];
    assign start  = go && seq_idle;
    assign wfull  = wcnt[AW];
    assign wempty = (wcnt == '0);
    assign rempty = (rcnt == '0);
    assign wpush  = wr_wdata && !wfull;
    assign rpop   = rd_rdata && !rempty;
    assign rflush = start && data_in[CTRL_DIR];

    assign err_set = (go && !seq_idle) || (wr_wdata && wfull) ||
                     (rd_rdata && rempty) || seq_abort;

    rtc_bus_seq #(
        .T_PULSE (T_PULSE),
        .T_HOLD  (T_HOLD),
        .T_GAP   (T_GAP)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_dir   (data_in[CTRL_DIR]),
        .start_addr  (addr_reg),
        .start_last  (clamp_last(data_in[CTRL_LEN_MSB:CTRL_LEN_LSB], BURST_DEPTH)),
        .wfifo_empty (wempty),
        .wfifo_head  (wmem[wrp]),
        .wfifo_pop   (seq_pop),
        .rfifo_push  (seq_push),
        .rfifo_data  (seq_rdata),
        .done_evt    (seq_done),
        .abort_evt   (seq_abort),
        .idle        (seq_idle),
        .busy        (seq_busy),
        .AD          (AD),
        .CS          (CS),
        .RD          (RD),
        .WR          (WR),
        .bus         (bus)
    );

    always_ff @(posedge clk) begin
        if (wpush)    wmem[wwp] <= data_in;
        if (seq_push) rmem[rwp] <= seq_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_reg  <= '0;
            rs_q      <= 1'b0;
            done_flag <= 1'b0;
            err_flag  <= 1'b0;
            irq_s1    <= 1'b1;
            irq_s2    <= 1'b1;
            wwp       <= '0;
            wrp       <= '0;
            wcnt      <= '0;
            rwp       <= '0;
            rrp       <= '0;
            rcnt      <= '0;
        end else begin
            rs_q   <= read_strobe;
            irq_s1 <= IRQ;
            irq_s2 <= irq_s1;
            if (wr_addr) addr_reg <= data_in;
            if (seq_done)       done_flag <= 1'b1;
            else if (rd_status) done_flag <= 1'b0;
            if (err_set)        err_flag <= 1'b1;
            else if (rd_status) err_flag <= 1'b0;

            if (wpush)   wwp <= wwp + 1'b1;
            if (seq_pop) wrp <= wrp + 1'b1;
            wcnt <= wcnt + {{AW{1'b0}}, wpush} - {{AW{1'b0}}, seq_pop};

            if (rflush) begin
                rwp  <= '0;
                rrp  <= '0;
                rcnt <= '0;
            end else begin
                if (seq_push) rwp <= rwp + 1'b1;
                if (rpop)     rrp <= rrp + 1'b1;
                rcnt <= rcnt + {{AW{1'b0}}, seq_push} - {{AW{1'b0}}, rpop};
            end
        end
    end

`ifdef IRQ_LATCH_EN
    logic irq_s3;
    always_ff @(posedge clk) begin
        if (!rst) begin
            irq_s3   <= 1'b1;
            irq_flag <= 1'b0;
        end else begin
            irq_s3 <= irq_s2;
            if (irq_s3 && !irq_s2) irq_flag <= 1'b1;
            else if (rd_status)    irq_flag <= 1'b0;
        end
    end
`else
    assign irq_flag = 1'b0;
`endif

    always_comb begin
        status              = 8'h00;
        status[ST_DONE]     = done_flag;
        status[ST_BUSY]     = seq_busy;
        status[ST_IRQ_LVL]  = !irq_s2;
        status[ST_REMPTY]   = rempty;
        status[ST_WFULL]    = wfull;
        status[ST_ERR]      = err_flag;
        status[ST_IRQ_FLAG] = irq_flag;
    end

    always_comb begin
        data_out = 8'h00;
        if (port_id == PORT_STATUS)
            data_out = status;
        else if (port_id == PORT_RDATA && !rempty)
            data_out = rmem[rrp];
    end

endmodule

// File: tb/tb_rtc_port_bridge.sv
// Directed bench for rtc_port_bridge with a simple RTC bus model answering read cycles.
module tb_rtc_port_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       read_strobe = 1'b0;
    logic       write_strobe = 1'b0;
    logic       IRQ = 1'b1;
    logic [7:0] port_id = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       AD, CS, RD, WR;
    wire  [7:0] bus;

    logic       probe_en = 1'b0;
    logic [7:0] model_mem [256];
    logic [7:0] model_addr = 8'h00;
    logic [7:0] addr_log [$];
    logic [7:0] data_log [$];
    logic       ad_q = 1'b1;
    logic       wd_q = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    assign bus = probe_en ? 8'h3C : (!RD ? model_mem[model_addr] : 8'hzz);

    rtc_port_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .read_strobe  (read_strobe),
        .write_strobe (write_strobe),
        .port_id      (port_id),
        .data_in      (data_in),
        .data_out     (data_out),
        .IRQ          (IRQ),
        .AD           (AD),
        .CS           (CS),
        .RD           (RD),
        .WR           (WR),
        .bus          (bus)
    );

    always @(negedge clk) begin
        if (!AD) model_addr = bus;
        if (!AD && ad_q) addr_log.push_back(bus);
        if (!CS && AD && !WR && !wd_q) data_log.push_back(bus);
        ad_q = AD;
        wd_q = !CS && AD && !WR;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic port_write(input logic [7:0] id, input logic [7:0] d);
        port_id      = id;
        data_in      = d;
        write_strobe = 1'b1;
        cyc();
        write_strobe = 1'b0;
    endtask

    task automatic port_read(input logic [7:0] id, output logic [7:0] v);
        port_id     = id;
        read_strobe = 1'b1;
        #1;
        v = data_out;
        cyc();
        read_strobe = 1'b0;
        cyc();
    endtask

    task automatic peek(input logic [7:0] id, output logic [7:0] v);
        port_id = id;
        #1;
        v = data_out;
    endtask

    // Called on the first cycle after go; walks one beat checking pins and driven bus.
    task automatic check_beat(input logic [7:0] a, input logic [7:0] wd, input logic rd);
        logic [3:0] e;
        for (int i = 0; i < 14; i++) begin
            if (i < 4)                e = 4'b0010;
            else if (i >= 8 && i < 12) e = rd ? 4'b1001 : 4'b1010;
            else                      e = 4'b1111;
            check($sformatf("pins_c%0d", i), {AD, CS, RD, WR}, e);
            if (i < 6)                check($sformatf("bus_addr_c%0d", i), bus, a);
            else if (i >= 8 && !rd)   check($sformatf("bus_wdata_c%0d", i), bus, wd);
            cyc();
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        port_id = 8'd1;
        #1;
        while (!data_out[0] && n < 200) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        int         n;
        logic [7:0] exp_a [4];
        logic [7:0] exp_d [4];

        for (int k = 0; k < 256; k++) model_mem[k] = 8'h00;
        model_mem[8'hFE] = 8'h11;
        model_mem[8'hFF] = 8'h22;
        model_mem[8'h00] = 8'h33;
        model_mem[8'h01] = 8'h44;

        // Reset state
        repeat (3) cyc();
        check("rst_pins", {AD, CS, RD, WR}, 4'b1111);
        peek(8'd1, v);  check("rst_status", v, 8'h08);
        peek(8'd2, v);  check("rst_rdata", v, 8'h00);
        peek(8'h55, v); check("unknown_port", v, 8'h00);
        probe_en = 1'b1; #1;
        check("rst_bus_hiz", bus, 8'h3C);
        probe_en = 1'b0;
        rst = 1'b1;
        cyc();

        // Single write beat
        port_write(8'd12, 8'h21);
        port_write(8'd15, 8'h5A);
        port_write(8'd13, 8'h01);
        check_beat(8'h21, 8'h5A, 1'b0);
        peek(8'd1, v);      check("wr_done_status", v, 8'h09);
        port_read(8'd1, v); check("wr_status_read", v, 8'h09);
        peek(8'd1, v);      check("wr_status_cleared", v, 8'h08);

        // Read burst of 4 across the address wrap
        addr_log.delete();
        port_write(8'd12, 8'hFE);
        port_write(8'd13, 8'h33);
        check_beat(8'hFE, 8'h00, 1'b1);
        wait_done(n);
        check("rd_burst_cycles", n, 42);
        exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        check("rd_addr_count", addr_log.size(), 4);
        if (addr_log.size() == 4)
            for (int k = 0; k < 4; k++) check($sformatf("rd_addr%0d", k), addr_log[k], exp_a[k]);
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int k = 0; k < 4; k++) begin
            port_read(8'd2, v);
            check($sformatf("rdata%0d", k), v, exp_d[k]);
        end
        peek(8'd1, v);      check("rd_done_status", v, 8'h09);
        port_read(8'd2, v); check("rdata_empty", v, 8'h00);
        peek(8'd1, v);      check("rdata_empty_err", v, 8'h29);
        port_read(8'd1, v); check("rd_status_read", v, 8'h29);
        peek(8'd1, v);      check("rd_status_cleared", v, 8'h08);

        // go while busy
        addr_log.delete();
        data_log.delete();
        port_write(8'd15, 8'h61);
        port_write(8'd15, 8'h62);
        port_write(8'd12, 8'h40);
        port_write(8'd13, 8'h11);
        repeat (5) cyc();
        port_write(8'd13, 8'h01);
        peek(8'd1, v);      check("busy_go_status", v, 8'h2A);
        wait_done(n);
        check("busy_burst_cycles", n, 22);
        check("busy_addr_count", addr_log.size(), 2);
        check("busy_data_count", data_log.size(), 2);
        if (addr_log.size() == 2) begin
            check("busy_addr0", addr_log[0], 8'h40);
            check("busy_addr1", addr_log[1], 8'h41);
        end
        if (data_log.size() == 2) begin
            check("busy_data0", data_log[0], 8'h61);
            check("busy_data1", data_log[1], 8'h62);
        end
        port_read(8'd1, v); check("busy_status_read", v, 8'h29);
        peek(8'd1, v);      check("busy_status_cleared", v, 8'h08);

        // Write FIFO overflow, then drain with an over-long (clamped) burst
        for (int k = 0; k < 5; k++) port_write(8'd15, 8'hA0 + 8'(k));
        peek(8'd1, v);      check("wfull_err_status", v, 8'h38);
        port_read(8'd1, v); check("wfull_status_read", v, 8'h38);
        peek(8'd1, v);      check("wfull_status_kept", v, 8'h18);
        addr_log.delete();
        data_log.delete();
        port_write(8'd12, 8'h80);
        port_write(8'd13, 8'hF1);
        wait_done(n);
        check("clamp_cycles", n, 56);
        peek(8'd1, v);      check("clamp_status", v, 8'h09);
        exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        check("clamp_data_count", data_log.size(), 4);
        if (data_log.size() == 4)
            for (int k = 0; k < 4; k++) check($sformatf("clamp_data%0d", k), data_log[k], exp_d[k]);
        port_read(8'd1, v);
        peek(8'd1, v);      check("clamp_status_cleared", v, 8'h08);

        // Write burst with empty write FIFO aborts immediately
        port_write(8'd13, 8'h01);
        check("abort_pins", {AD, CS, RD, WR}, 4'b1111);
        peek(8'd1, v);      check("abort_status", v, 8'h29);
        port_read(8'd1, v);
        peek(8'd1, v);      check("abort_status_cleared", v, 8'h08);

        // Reset in the middle of the data phase
        port_write(8'd15, 8'h81);
        port_write(8'd15, 8'h82);
        port_write(8'd12, 8'h10);
        port_write(8'd13, 8'h01);
        repeat (9) cyc();
        check("mid_data_pins", {AD, CS, RD, WR}, 4'b1010);
        check("mid_data_bus", bus, 8'h81);
        rst = 1'b0;
        cyc();
        check("mid_rst_pins", {AD, CS, RD, WR}, 4'b1111);
        peek(8'd1, v);      check("mid_rst_status", v, 8'h08);
        probe_en = 1'b1; #1;
        check("mid_rst_bus_hiz", bus, 8'h3C);
        probe_en = 1'b0;
        rst = 1'b1;
        cyc();
        port_write(8'd13, 8'h01);
        peek(8'd1, v);      check("mid_rst_wfifo_flushed", v, 8'h29);
        port_read(8'd1, v);

        // IRQ level and optional latched flag
        IRQ = 1'b0;
        repeat (4) cyc();
        peek(8'd1, v);
`ifdef IRQ_LATCH_EN
        check("irq_low_status", v, 8'h4C);
`else
        check("irq_low_status", v, 8'h0C);
`endif
        IRQ = 1'b1;
        repeat (4) cyc();
        peek(8'd1, v);
`ifdef IRQ_LATCH_EN
        check("irq_high_status", v, 8'h48);
`else
        check("irq_high_status", v, 8'h08);
`endif
        port_read(8'd1, v);
        peek(8'd1, v);      check("irq_status_cleared", v, 8'h08);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
